// File: rtl/bcd_xs3_word_converter_pkg.sv
// Shared types and constants for the multi-digit BCD <-> excess-3 word converter.
// Optional invalid-digit checking is enabled with the XS3_ERR_CHECK_EN macro.
package bcd_xs3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int          DIGIT_W      = 4;
  localparam logic [3:0]  XS3_OFFSET   = 4'd3;
  localparam logic        MODE_BCD2XS3 = 1'b0;
  localparam logic        MODE_XS32BCD = 1'b1;
  localparam logic [3:0]  BCD_MAX      = 4'd9;
  localparam logic [3:0]  XS3_MIN      = 4'd3;
  localparam logic [3:0]  XS3_MAX      = 4'd12;

endpackage

// File: rtl/bcd_xs3_word_converter_if.sv
// Valid/ready input and output channels of the BCD <-> excess-3 word converter.
// The converter uses the slave modport; the word producer/consumer uses master.
interface bcd_xs3_word_converter_if #(
  parameter int DIGITS = 4
);
  logic                in_valid;
  logic                in_ready;
  logic                mode;
  logic [4*DIGITS-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [4*DIGITS-1:0] out_data;
  logic                out_err;

  modport slave (
    input  in_valid, mode, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err
  );

  modport master (
    output in_valid, mode, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/bcd_xs3_word_converter_digit_conv.sv
// Single-digit BCD <-> excess-3 converter (mod-16 add/subtract of 3).
// The invalid flag is only generated when XS3_ERR_CHECK_EN is defined.
module xs3_digit_conv
  import bcd_xs3_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic               mode,
  output logic [DIGIT_W-1:0] result,
  output logic               invalid
);

  assign result = (mode == MODE_BCD2XS3) ? (digit + XS3_OFFSET) : (digit - XS3_OFFSET);

`ifdef XS3_ERR_CHECK_EN
  assign invalid = (mode == MODE_BCD2XS3) ? (digit > BCD_MAX)
                                          : ((digit < XS3_MIN) || (digit > XS3_MAX));
`else
  assign invalid = 1'b0;
`endif

endmodule

// File: rtl/bcd_xs3_word_converter.sv
// Word-level BCD <-> excess-3 converter: one digit per clock, LSD first, held output.
// Per-word sticky error flag is present only when XS3_ERR_CHECK_EN is defined.
//
//  state | meaning
//  IDLE  | in_ready=1, waiting for a word
//  CONV  | converting digit cnt each clock
//  DONE  | out_valid=1, result held until out_ready
module bcd_xs3_word_converter
  import bcd_xs3_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  bcd_xs3_word_converter_if.slave  bus
);

  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

  state_t state_q, state_d;

  logic [CNT_W-1:0]                cnt_q;
  logic                            mode_q;
  logic [DIGITS-1:0][DIGIT_W-1:0]  word_q;
  logic [DIGITS-1:0][DIGIT_W-1:0]  res_q;
  logic [DIGITS-1:0][DIGIT_W-1:0]  res_d;
  logic [DIGITS-1:0][DIGIT_W-1:0]  out_data_q;

  logic [DIGIT_W-1:0] digit_cur;
  logic [DIGIT_W-1:0] digit_conv;
  logic               digit_bad;
  logic               last;
  logic               accept;
  logic               in_ready_c;
  logic               out_valid_c;

  assign digit_cur = word_q[cnt_q];
  assign last      = (cnt_q == CNT_LAST);
  assign accept    = bus.in_valid && in_ready_c;

  xs3_digit_conv u_conv (
    .digit   (digit_cur),
    .mode    (mode_q),
    .result  (digit_conv),
    .invalid (digit_bad)
  );

  always_comb begin
    res_d        = res_q;
    res_d[cnt_q] = digit_conv;
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_d = CONV;
      end
      CONV: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result is built in res_q; out_data_q only moves on entry to DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q      <= '0;
      mode_q     <= MODE_BCD2XS3;
      word_q     <= '0;
      res_q      <= '0;
      out_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            word_q <= bus.in_data;
            mode_q <= bus.mode;
            res_q  <= '0;
            cnt_q  <= '0;
          end
        end
        CONV: begin
          res_q <= res_d;
          if (last) out_data_q <= res_d;
          else      cnt_q      <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef XS3_ERR_CHECK_EN
  logic err_q;
  logic out_err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      err_q     <= 1'b0;
      out_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) err_q <= 1'b0;
        CONV: begin
          err_q <= err_q | digit_bad;
          if (last) out_err_q <= err_q | digit_bad;
        end
        default: ;
      endcase
    end
  end

  assign bus.out_err = out_err_q;
`else
  logic err_unused;
  assign err_unused  = digit_bad;
  assign bus.out_err = 1'b0;
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_bcd_xs3_word_converter.sv
// Self-checking bench for bcd_xs3_word_converter (DIGITS=4 and DIGITS=1 instances).
// Expected words come from a per-digit model pushed to a scoreboard queue.
module tb_bcd_xs3_word_converter;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  bcd_xs3_word_converter_if #(.DIGITS(4)) bus4 ();
  bcd_xs3_word_converter_if #(.DIGITS(1)) bus1 ();

  bcd_xs3_word_converter #(.DIGITS(4)) dut4 (.clock(clock), .reset(reset), .bus(bus4));
  bcd_xs3_word_converter #(.DIGITS(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));

  function automatic exp_t model(input logic m, input logic [15:0] d, input int n);
    exp_t       r;
    logic [3:0] nib;
    logic       bad;
    r = '0;
    for (int i = 0; i < n; i++) begin
      nib = d[4*i +: 4];
      if (!m) begin
        r.data[4*i +: 4] = nib + 4'd3;
        bad = (nib > 4'd9);
      end else begin
        r.data[4*i +: 4] = nib - 4'd3;
        bad = (nib < 4'd3) || (nib > 4'd12);
      end
`ifdef XS3_ERR_CHECK_EN
      r.err = r.err | bad;
`endif
    end
    return r;
  endfunction

  // Drives one word into dut4 and retires it; lat counts edges after the accepting edge.
  task automatic run4(input logic m, input logic [15:0] d,
                      output logic [15:0] od, output logic oe, output int lat, output bit to);
    bus4.mode     = m;
    bus4.in_data  = d;
    bus4.in_valid = 1'b1;
    @(posedge clock); #1;
    bus4.in_valid = 1'b0;
    lat = 0;
    to  = 1'b1;
    while (lat < 20) begin
      if (bus4.out_valid) begin
        to = 1'b0;
        break;
      end
      @(posedge clock); #1;
      lat++;
    end
    od = bus4.out_data;
    oe = bus4.out_err;
    bus4.out_ready = 1'b1;
    @(posedge clock); #1;
    bus4.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (bus4.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus4.in_ready); end
    checks++; if (bus4.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus4.out_valid); end
    checks++; if (bus4.out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got %h want 0000", bus4.out_data); end
    checks++; if (bus4.out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got %b want 0", bus4.out_err); end
    checks++; if (bus1.in_ready !== 1'b1) begin errors++; $display("FAIL reset_d1_in_ready got %b want 1", bus1.in_ready); end
    reset = 1'b0;
  endtask

  task automatic test_words(input string name, input logic m, input logic [15:0] d);
    logic [15:0] od; logic oe; int lat; bit to; exp_t e;
    sb.push_back(model(m, d, 4));
    run4(m, d, od, oe, lat, to);
    e = sb.pop_front();
    checks++; if (to) begin errors++; $display("FAIL %s_timeout no out_valid within 20 edges", name); end
    // valid on the 5th edge counting the accepting edge
    checks++; if (lat != 4) begin errors++; $display("FAIL %s_latency got %0d want 4", name, lat); end
    checks++; if (od !== e.data) begin errors++; $display("FAIL %s_data got %h want %h", name, od, e.data); end
    checks++; if (oe !== e.err) begin errors++; $display("FAIL %s_err got %b want %b", name, oe, e.err); end
  endtask

  task automatic test_basic();
    test_words("bcd2xs3_0429", 1'b0, 16'h0429);
    test_words("xs32bcd_375c", 1'b1, 16'h375C);
    test_words("bcd2xs3_9999", 1'b0, 16'h9999);
  endtask

  task automatic test_err();
    test_words("err_00a1", 1'b0, 16'h00A1);
    test_words("err_3332", 1'b1, 16'h3332);
    test_words("err_xs3_d", 1'b1, 16'h4D55);
  endtask

  task automatic test_roundtrip();
    logic [15:0] bcd, od, od2; logic oe, oe2; int lat, v; bit to; exp_t e;
    for (int k = 0; k < 16; k++) begin
      v   = $urandom_range(0, 9999);
      bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
      sb.push_back(model(1'b0, bcd, 4));
      run4(1'b0, bcd, od, oe, lat, to);
      e = sb.pop_front();
      checks++; if (to || od !== e.data || oe !== e.err) begin errors++; $display("FAIL rt_fwd in %h got %h/%b want %h/%b", bcd, od, oe, e.data, e.err); end
      sb.push_back('{data: bcd, err: 1'b0});
      run4(1'b1, od, od2, oe2, lat, to);
      e = sb.pop_front();
      checks++; if (to || od2 !== e.data || oe2 !== e.err) begin errors++; $display("FAIL rt_back in %h got %h/%b want %h/%b", od, od2, oe2, e.data, e.err); end
    end
  endtask

  task automatic test_backpressure();
    exp_t e; int lat;
    sb.push_back(model(1'b0, 16'h1357, 4));
    e = sb.pop_front();
    bus4.mode = 1'b0; bus4.in_data = 16'h1357; bus4.in_valid = 1'b1;
    @(posedge clock); #1;
    bus4.in_valid = 1'b0;
    lat = 0;
    while (!bus4.out_valid && lat < 20) begin @(posedge clock); #1; lat++; end
    checks++; if (!bus4.out_valid) begin errors++; $display("FAIL bp_reach_done got %b want 1", bus4.out_valid); end
    for (int k = 0; k < 6; k++) begin
      bus4.in_valid = k[0];
      bus4.in_data  = 16'h8642;
      bus4.mode     = 1'b1;
      @(posedge clock); #1;
      checks++; if (bus4.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid cyc %0d got %b want 1", k, bus4.out_valid); end
      checks++; if (bus4.out_data !== e.data) begin errors++; $display("FAIL bp_out_data cyc %0d got %h want %h", k, bus4.out_data, e.data); end
      checks++; if (bus4.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b want 0", k, bus4.in_ready); end
    end
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;
    @(posedge clock); #1;
    bus4.out_ready = 1'b0;
    checks++; if (bus4.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", bus4.in_ready); end
    checks++; if (bus4.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got %b want 0", bus4.out_valid); end
    checks++; if (bus4.out_data !== e.data) begin errors++; $display("FAIL bp_idle_hold got %h want %h", bus4.out_data, e.data); end
  endtask

  task automatic test_reset_mid();
    bus4.mode = 1'b0; bus4.in_data = 16'h9876; bus4.in_valid = 1'b1;
    @(posedge clock); #1;
    bus4.in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++; if (bus4.in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b want 1", bus4.in_ready); end
    checks++; if (bus4.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got %b want 0", bus4.out_valid); end
    checks++; if (bus4.out_data !== 16'h0000) begin errors++; $display("FAIL rmid_out_data got %h want 0000", bus4.out_data); end
    test_words("after_rst", 1'b0, 16'h1234);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus4.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready word %0d got %b want 1", k, bus4.in_ready); end
      test_words("b2b", k[0], 16'h5678 + 16'(k * 16'h0101));
    end
  endtask

  task automatic test_digits1();
    int lat; exp_t e;
    for (int k = 0; k < 2; k++) begin
      sb.push_back(model(1'b0, (k == 0) ? 16'h0005 : 16'h000A, 1));
      bus1.mode = 1'b0; bus1.in_data = (k == 0) ? 4'h5 : 4'hA; bus1.in_valid = 1'b1;
      @(posedge clock); #1;
      bus1.in_valid = 1'b0;
      lat = 0;
      while (!bus1.out_valid && lat < 20) begin @(posedge clock); #1; lat++; end
      e = sb.pop_front();
      checks++; if (lat != 1) begin errors++; $display("FAIL d1_latency got %0d want 1", lat); end
      checks++; if (bus1.out_data !== e.data[3:0]) begin errors++; $display("FAIL d1_data got %h want %h", bus1.out_data, e.data[3:0]); end
      checks++; if (bus1.out_err !== e.err) begin errors++; $display("FAIL d1_err got %b want %b", bus1.out_err, e.err); end
      bus1.out_ready = 1'b1;
      @(posedge clock); #1;
      bus1.out_ready = 1'b0;
    end
  endtask

  initial begin
    bus4.in_valid = 1'b0; bus4.mode = 1'b0; bus4.in_data = '0; bus4.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.mode = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_err();
    test_roundtrip();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_digits1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
